// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S stereo frame path.
// Holds the pairing FSM state type and channel encodings.
package i2s_pkg;

   typedef enum logic {
      WAIT_LEFT = 1'b0,
      HAVE_LEFT = 1'b1
   } pair_state_t;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   localparam int DEFAULT_AUDIO_WORD_LEN = 24;

endpackage

// File: rtl/i2s_frame_fifo.sv
// First-word-fall-through frame FIFO for the stereo frame buffer.
// Ports: clk_i/rst_ni clock and async active-low reset; clear_i sync
// flush; push_i/data_i write side; pop_i read side (ignored when
// empty); data_o head word (0 when empty); full_o, empty_o, level_o.
module i2s_frame_fifo
   import i2s_pkg::*;
#(
   parameter int WIDTH = 2 * DEFAULT_AUDIO_WORD_LEN,
   parameter int DEPTH = 8,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [LW-1:0]    r_level;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_pop   = pop_i & ~w_empty;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_push  = push_i & (~w_full | w_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (clear_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage needs no reset: data_o is masked while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (w_push && !clear_i) r_mem[r_wptr] <= data_i;
   end

   assign data_o  = w_empty ? '0 : r_mem[r_rptr];
   assign full_o  = w_full;
   assign empty_o = w_empty;
   assign level_o = r_level;

endmodule

// File: rtl/i2s_stereo_frame_buffer.sv
// Pairs I2S left/right channel words into stereo frames and buffers them.
// Ports: clk_i, rst_ni, enable_i, clear_i; sample_i/sample_valid_i/
// channel_i word input; frame_left_o/frame_right_o/frame_valid_o/
// frame_ready_i output stream; fill_level_o, overflow_o,
// overflow_cnt_o, sync_err_o status.
module i2s_stereo_frame_buffer
   import i2s_pkg::*;
#(
   parameter int AUDIO_WORD_LEN = DEFAULT_AUDIO_WORD_LEN,
   parameter int FIFO_DEPTH     = 8,
   parameter int OVF_CNT_W      = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        enable_i,
   input  logic                        clear_i,
   input  logic [AUDIO_WORD_LEN-1:0]   sample_i,
   input  logic                        sample_valid_i,
   input  logic                        channel_i,
   output logic [AUDIO_WORD_LEN-1:0]   frame_left_o,
   output logic [AUDIO_WORD_LEN-1:0]   frame_right_o,
   output logic                        frame_valid_o,
   input  logic                        frame_ready_i,
   output logic [$clog2(FIFO_DEPTH):0] fill_level_o,
   output logic                        overflow_o,
   output logic [OVF_CNT_W-1:0]        overflow_cnt_o,
   output logic                        sync_err_o
);

   localparam int FW = 2 * AUDIO_WORD_LEN;

   pair_state_t               r_state;
   pair_state_t               w_state_nxt;
   logic [AUDIO_WORD_LEN-1:0] r_left;
   logic [AUDIO_WORD_LEN-1:0] w_left_nxt;
   logic                      w_push;
   logic                      w_sync_nxt;
   logic                      r_sync_err;
   logic                      r_ovf;
   logic [OVF_CNT_W-1:0]      r_ovf_cnt;

   logic [FW-1:0]             w_head;
   logic                      w_full;
   logic                      w_empty;
   logic                      w_drop;

   always_comb begin
      w_state_nxt = r_state;
      w_left_nxt  = r_left;
      w_push      = 1'b0;
      w_sync_nxt  = 1'b0;
      if (!enable_i) begin
         // Drop any half-built frame while disabled.
         w_state_nxt = WAIT_LEFT;
      end else if (sample_valid_i) begin
         unique case (r_state)
            WAIT_LEFT: begin
               if (channel_i == CH_LEFT) begin
                  w_left_nxt  = sample_i;
                  w_state_nxt = HAVE_LEFT;
               end else begin
                  w_sync_nxt = 1'b1;
               end
            end
            HAVE_LEFT: begin
               if (channel_i == CH_LEFT) begin
                  w_left_nxt = sample_i;
                  w_sync_nxt = 1'b1;
               end else begin
                  w_push      = 1'b1;
                  w_state_nxt = WAIT_LEFT;
               end
            end
            default: w_state_nxt = WAIT_LEFT;
         endcase
      end
   end

   // Full implies non-empty, so ready alone means a pop this edge.
   assign w_drop = w_push & w_full & ~frame_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= WAIT_LEFT;
         r_left     <= '0;
         r_sync_err <= 1'b0;
         r_ovf      <= 1'b0;
         r_ovf_cnt  <= '0;
      end else if (clear_i) begin
         r_state    <= WAIT_LEFT;
         r_left     <= '0;
         r_sync_err <= 1'b0;
         r_ovf      <= 1'b0;
         r_ovf_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_left     <= w_left_nxt;
         r_sync_err <= w_sync_nxt;
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
         end
      end
   end

   i2s_frame_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (w_push),
      .data_i  ({r_left, sample_i}),
      .pop_i   (frame_ready_i),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .level_o (fill_level_o)
   );

   assign frame_left_o   = w_head[FW-1:AUDIO_WORD_LEN];
   assign frame_right_o  = w_head[AUDIO_WORD_LEN-1:0];
   assign frame_valid_o  = ~w_empty;
   assign overflow_o     = r_ovf;
   assign overflow_cnt_o = r_ovf_cnt;
   assign sync_err_o     = r_sync_err;

endmodule

// File: tb/tb_i2s_stereo_frame_buffer.sv
// Self-checking bench for i2s_stereo_frame_buffer.
// Vector table, hand sequences and a queue-based reference model.
module tb_i2s_stereo_frame_buffer;

   localparam int W = 24;
   localparam int D = 8;

   logic clk = 1'b0;
   logic rst_n, en, clr, sv, ch, rdy;
   logic [W-1:0] smp;

   logic [W-1:0] fl, fr;
   logic fv, ovf, serr;
   logic [3:0] fill;
   logic [15:0] cnt;

   logic [W-1:0] fl_s, fr_s;
   logic fv_s, ovf_s, serr_s;
   logic [3:0] fill_s;
   logic [1:0] cnt_s;

   always #5 clk = ~clk;

   i2s_stereo_frame_buffer #(
      .AUDIO_WORD_LEN(W), .FIFO_DEPTH(D), .OVF_CNT_W(16)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
      .sample_i(smp), .sample_valid_i(sv), .channel_i(ch),
      .frame_left_o(fl), .frame_right_o(fr), .frame_valid_o(fv),
      .frame_ready_i(rdy), .fill_level_o(fill), .overflow_o(ovf),
      .overflow_cnt_o(cnt), .sync_err_o(serr)
   );

   // Narrow counter copy so saturation is reachable quickly.
   i2s_stereo_frame_buffer #(
      .AUDIO_WORD_LEN(W), .FIFO_DEPTH(D), .OVF_CNT_W(2)
   ) dut_s (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
      .sample_i(smp), .sample_valid_i(sv), .channel_i(ch),
      .frame_left_o(fl_s), .frame_right_o(fr_s), .frame_valid_o(fv_s),
      .frame_ready_i(rdy), .fill_level_o(fill_s), .overflow_o(ovf_s),
      .overflow_cnt_o(cnt_s), .sync_err_o(serr_s)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   logic [47:0] mq[$];
   logic [47:0] obs[$];
   bit          m_have;
   logic [W-1:0] m_left;
   bit          m_ovf;
   int          m_drops;
   bit          m_sync;

   task automatic model_reset();
      mq.delete();
      m_have  = 0;
      m_left  = '0;
      m_ovf   = 0;
      m_drops = 0;
      m_sync  = 0;
   endtask

   task automatic model_step();
      bit pop;
      bit push;
      logic [47:0] f;
      f = '0;
      push = 0;
      if (clr) begin
         model_reset();
         return;
      end
      pop = rdy && (mq.size() > 0);
      m_sync = 0;
      if (!en) begin
         m_have = 0;
      end else if (sv) begin
         if (ch == 1'b0) begin
            if (m_have) m_sync = 1;
            m_left = smp;
            m_have = 1;
         end else if (!m_have) begin
            m_sync = 1;
         end else begin
            push = 1;
            f = {m_left, smp};
            m_have = 0;
         end
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
         if (mq.size() < D) mq.push_back(f);
         else begin
            m_ovf = 1;
            m_drops++;
         end
      end
   endtask

   task automatic model_check();
      chk("valid", fv, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("left", fl, mq[0][47:24]);
         chk("right", fr, mq[0][23:0]);
      end
      chk("fill", fill, mq.size());
      chk("ovf", ovf, m_ovf);
      chk("ovf_cnt", cnt, (m_drops > 65535) ? 65535 : m_drops);
      chk("ovf_cnt_sat", cnt_s, (m_drops > 3) ? 3 : m_drops);
      chk("sync_err", serr, m_sync);
   endtask

   task automatic cyc(bit e, bit c, bit v, bit h, logic [W-1:0] s, bit r);
      en = e; clr = c; sv = v; ch = h; smp = s; rdy = r;
      if (fv && r) obs.push_back({fl, fr});
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_check();
   endtask

   task automatic idle(bit r);
      cyc(1, 0, 0, 0, '0, r);
   endtask

   typedef struct {
      bit          en;
      bit          sv;
      bit          ch;
      logic [W-1:0] smp;
      bit          rdy;
      bit          e_valid;
      logic [W-1:0] e_l;
      logic [W-1:0] e_r;
      int          e_fill;
      bit          e_sync;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{1, 1, 0, 24'h123456, 0, 0, 24'h0, 24'h0, 0, 0};
      tbl[1]  = '{1, 1, 1, 24'hABCDEF, 0, 1, 24'h123456, 24'hABCDEF, 1, 0};
      tbl[2]  = '{1, 0, 0, 24'h0, 1, 0, 24'h0, 24'h0, 0, 0};
      tbl[3]  = '{1, 1, 1, 24'h000001, 0, 0, 24'h0, 24'h0, 0, 1};
      tbl[4]  = '{1, 1, 0, 24'h111111, 0, 0, 24'h0, 24'h0, 0, 0};
      tbl[5]  = '{1, 1, 0, 24'h222222, 0, 0, 24'h0, 24'h0, 0, 1};
      tbl[6]  = '{1, 1, 1, 24'h333333, 0, 1, 24'h222222, 24'h333333, 1, 0};
      tbl[7]  = '{1, 0, 0, 24'h0, 0, 1, 24'h222222, 24'h333333, 1, 0};
      tbl[8]  = '{1, 1, 0, 24'h444444, 1, 0, 24'h0, 24'h0, 0, 0};
      tbl[9]  = '{0, 1, 1, 24'h555555, 0, 0, 24'h0, 24'h0, 0, 0};
      tbl[10] = '{1, 1, 1, 24'h666666, 0, 0, 24'h0, 24'h0, 0, 1};
      tbl[11] = '{1, 0, 0, 24'h0, 0, 0, 24'h0, 24'h0, 0, 0};

      rst_n = 0; en = 0; clr = 0; sv = 0; ch = 0; smp = '0; rdy = 0;
      model_reset();
      #12;
      chk("rst_valid", fv, 0);
      chk("rst_left", fl, 0);
      chk("rst_right", fr, 0);
      chk("rst_fill", fill, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_sync", serr, 0);
      @(negedge clk);
      rst_n = 1;

      // Pairing, sync errors, enable gating.
      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].en, 0, tbl[i].sv, tbl[i].ch, tbl[i].smp, tbl[i].rdy);
         chk("tbl_valid", fv, tbl[i].e_valid);
         chk("tbl_fill", fill, tbl[i].e_fill);
         chk("tbl_sync", serr, tbl[i].e_sync);
         if (tbl[i].e_valid) begin
            chk("tbl_left", fl, tbl[i].e_l);
            chk("tbl_right", fr, tbl[i].e_r);
         end
      end

      // Overflow: 10 frames into depth 8, then 3 more for saturation.
      for (int k = 1; k <= 13; k++) begin
         cyc(1, 0, 1, 0, W'(k), 0);
         cyc(1, 0, 1, 1, W'(k + 'h100), 0);
         if (k == 10) begin
            chk("ovf10_fill", fill, 8);
            chk("ovf10_flag", ovf, 1);
            chk("ovf10_cnt", cnt, 2);
         end
      end
      chk("ovf13_cnt", cnt, 5);
      chk("ovf13_cnt_sat", cnt_s, 3);
      for (int k = 1; k <= 8; k++) begin
         chk("drain_valid", fv, 1);
         chk("drain_left", fl, k);
         chk("drain_right", fr, k + 'h100);
         idle(1);
      end
      chk("drain_empty", fv, 0);
      idle(1);
      chk("empty_ready_fill", fill, 0);

      // Full FIFO with push and pop on the same edge.
      for (int k = 1; k <= 8; k++) begin
         cyc(1, 0, 1, 0, W'(k + 'h20), 0);
         cyc(1, 0, 1, 1, W'(k + 'h40), 0);
      end
      cyc(1, 0, 1, 0, 24'h55, 0);
      cyc(1, 0, 1, 1, 24'h66, 1);
      chk("fullpop_fill", fill, 8);
      chk("fullpop_cnt", cnt, 5);
      chk("fullpop_head", fl, 'h22);

      // Clear with 5 frames stored.
      idle(1); idle(1); idle(1);
      chk("preclr_fill", fill, 5);
      cyc(1, 1, 0, 0, '0, 1);
      chk("clr_fill", fill, 0);
      chk("clr_valid", fv, 0);
      chk("clr_ovf", ovf, 0);
      chk("clr_cnt", cnt, 0);

      // Random backpressure over 100 incrementing frames.
      obs.delete();
      for (int i = 0; i < 100; i++) begin
         while (mq.size() >= 7) idle(1);
         cyc(1, 0, 1, 0, W'(2 * i), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 1)));
         cyc(1, 0, 1, 1, W'(2 * i + 1), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 1)));
      end
      repeat (12) idle(1);
      chk("rand_count", obs.size(), 100);
      for (int i = 0; i < obs.size() && i < 100; i++)
         chk("rand_frame", obs[i], {W'(2 * i), W'(2 * i + 1)});

      // Asynchronous reset mid-stream.
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 1, 0, W'(k + 'h70), 0);
         cyc(1, 0, 1, 1, W'(k + 'h80), 0);
      end
      cyc(1, 0, 1, 0, 24'h99, 0);
      cyc(1, 0, 1, 0, 24'h9A, 0);
      chk("pre_rst_sync", serr, 1);
      rst_n = 0;
      #1;
      chk("arst_valid", fv, 0);
      chk("arst_left", fl, 0);
      chk("arst_right", fr, 0);
      chk("arst_fill", fill, 0);
      chk("arst_sync", serr, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      cyc(1, 0, 1, 1, 24'h1, 0);
      idle(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2s_stereo_frame_buffer.md
Name: i2s_stereo_frame_buffer

Overview:
Downstream of the I2S receiver. Takes the receiver's per-channel word stream and pairs left and right words into stereo frames. Buffers the frames in a small first-word-fall-through FIFO and presents them on a valid/ready stream to the DSP/bus side. Pairing and buffer faults are reported as a sync-error pulse and sticky overflow status.

Parameters:
AUDIO_WORD_LEN, 24, bits per channel word; must match the receiver.
FIFO_DEPTH, 8, stereo frames stored; power of two, 2..64.
OVF_CNT_W, 16, width of the saturating overflow counter.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  block enable; input side only
clear_i  in  1  synchronous flush of FIFO, pairing state and error status
sample_i  in  AUDIO_WORD_LEN  channel word from the receiver
sample_valid_i  in  1  single-cycle strobe; sample_i is valid in this cycle
channel_i  in  1  channel of sample_i: 0 = left, 1 = right
frame_left_o  out  AUDIO_WORD_LEN  left word of the head frame
frame_right_o  out  AUDIO_WORD_LEN  right word of the head frame
frame_valid_o  out  1  FIFO not empty
frame_ready_i  in  1  consumer accepts the head frame
fill_level_o  out  $clog2(FIFO_DEPTH)+1  frames currently stored
overflow_o  out  1  sticky; at least one frame was dropped because the FIFO was full
overflow_cnt_o  out  OVF_CNT_W  dropped-frame count; saturates at all-ones
sync_err_o  out  1  one-cycle pulse on a pairing violation

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - All outputs are 0.
  - FIFO is empty; pairing FSM is in WAIT_LEFT; the latched left word is 0.
- Pairing FSM, evaluated only when enable_i=1 and sample_valid_i=1:
  - WAIT_LEFT, left word: latch sample_i -> HAVE_LEFT.
  - WAIT_LEFT, right word: discard it, pulse sync_err_o, stay in WAIT_LEFT.
  - HAVE_LEFT, left word: overwrite the latched left word, pulse sync_err_o, stay in HAVE_LEFT.
  - HAVE_LEFT, right word: push {latched left, sample_i} into the FIFO on the same edge -> WAIT_LEFT.
- sync_err_o is registered: high for exactly the cycle after the offending strobe.
- enable_i=0:
  - Strobes are ignored and the FSM is forced to WAIT_LEFT, so a half-built frame is discarded.
  - The output side keeps draining.
- Push latency:
  - A right word sampled at edge N into an empty FIFO gives frame_valid_o=1 from edge N onward (one-cycle strobe-to-valid).
  - frame_left_o/frame_right_o are valid in the same cycle as frame_valid_o.
- Pop: on an edge with frame_valid_o & frame_ready_i, the head frame is removed and the next frame appears after that edge.
- frame_*_o hold their value while frame_valid_o=1 and frame_ready_i=0.
- Full FIFO:
  - A push with no simultaneous pop drops the new frame.
  - overflow_o is set to 1; overflow_cnt_o increments by 1, saturating at 2^OVF_CNT_W-1.
  - The FIFO contents are unchanged.
- Full FIFO with push and pop on the same edge: both take effect; no drop, fill level unchanged.
- Empty FIFO: frame_ready_i is ignored; pointers do not move.
- fill_level_o changes +1 on push only, -1 on pop only, 0 on both or neither. Range is 0..FIFO_DEPTH.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; full/empty is decided from fill_level_o.
- clear_i=1:
  - Next edge: FIFO empty, FSM in WAIT_LEFT, overflow_o=0, overflow_cnt_o=0, sync_err_o=0.
  - clear_i has priority over a simultaneous push or pop, which are lost.
- Reset mid-operation: same state as power-on reset; in-flight frames are lost, no pulse.

Decomposition:
- Package i2s_pkg:
  - pair_state_t enum {WAIT_LEFT, HAVE_LEFT}.
  - CH_LEFT=1'b0, CH_RIGHT=1'b1.
  - DEFAULT_AUDIO_WORD_LEN=24.
- Sub-module i2s_frame_fifo:
  - Parameters WIDTH (=2*AUDIO_WORD_LEN) and DEPTH.
  - Synchronous, first-word fall-through, with push/pop/full/empty/level and a clear input.
- The top level holds the pairing FSM, the overflow/sync-error logic and the FIFO instance.

Test Plan:
- Pairing: strobe L=0x123456 then R=0xABCDEF, ready=1 -> one frame left=0x123456 right=0xABCDEF, valid high one cycle after the R strobe, sync_err_o never high.
- Sync errors:
  - R=0x000001 first, then L=0x111111, L=0x222222, R=0x333333 -> sync_err_o pulses twice (after the first R and after the second L).
  - Exactly one frame is pushed: {0x222222,0x333333}.
- Overflow: ready=0, push 10 frames with DEPTH=8 -> fill_level_o=8, overflow_o=1, overflow_cnt_o=2; drain yields frames 1..8 in order.
- Full with simultaneous pop: FIFO full, ready=1 on the same edge as a push -> no drop, fill_level_o stays 8, overflow_cnt_o unchanged.
- Backpressure and wrap: random ready over 100 frames with an incrementing pattern -> output sequence equals input sequence, no loss, pointers wrap at least 10 times.
- Clear, enable and reset:
  - clear_i pulse with 5 stored frames -> fill=0, valid=0, overflow status cleared.
  - enable_i=0 between L and R -> that R is ignored, and the next R raises sync_err_o.
  - rst_ni asserted mid-stream -> all outputs 0 immediately.
